// File: rtl/data_ram_pipe.sv
// data_ram_pipe: byte-enable data RAM slave with a fixed-latency, in-order response FIFO.
// Defining DATA_RAM_BYTE_SWAP_EN stores bytes reversed within each word (big-endian images).
module data_ram_pipe #(
    parameter int          DEPTH        = 8000,
    parameter logic [15:0] BASE_ADDR_HI = 16'h0010,
    parameter int          READ_LAT     = 1,
    parameter int          RSP_DEPTH    = 4,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_in,
    input  logic [31:0] data_add_in,
    input  logic        data_we_in,
    input  logic [3:0]  data_be_in,
    input  logic [31:0] data_wdata_in,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        data_rready_in
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(RSP_DEPTH);

    logic [31:0] mem [DEPTH];
    logic [32:0] r_fifo [RSP_DEPTH];
    logic [PW:0] r_wp, r_rp, r_cnt;
    logic [READ_LAT-1:0] w_pv;
    logic [READ_LAT-1:0][32:0] w_pd;
    logic [IW-1:0] w_idx;
    logic [31:0] w_wd, w_rd;
    logic [3:0] w_be;
    logic [32:0] w_head;
    logic w_acc, w_in, w_pop, w_unused;

    function automatic logic [31:0] f_swap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

`ifdef DATA_RAM_BYTE_SWAP_EN
    assign w_wd = f_swap(data_wdata_in);
    assign w_be = {data_be_in[0], data_be_in[1], data_be_in[2], data_be_in[3]};
    assign w_rd = f_swap(mem[w_idx]);
`else
    assign w_wd = data_wdata_in;
    assign w_be = data_be_in;
    assign w_rd = mem[w_idx];
`endif

    assign w_unused   = ^data_add_in[1:0];
    assign w_idx      = data_add_in[IW+1:2];
    assign w_in       = (data_add_in[31:16] == BASE_ADDR_HI) && (32'(data_add_in[15:2]) < DEPTH);
    assign data_gnt_o = 32'(r_cnt) < RSP_DEPTH;
    assign w_acc      = data_req_in & data_gnt_o & ~rst;
    assign w_pv[0]    = w_acc;
    assign w_pd[0]    = {~w_in, (w_in & ~data_we_in) ? w_rd : 32'd0};

    // byte-lane writes for accepted in-window stores
    always_ff @(posedge clk)
        if (w_acc & w_in & data_we_in)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];

    for (genvar k = 1; k < READ_LAT; k++) begin : g_pipe
        logic        r_v;
        logic [32:0] r_d;
        // delay stage carrying {err, rdata} towards the response FIFO
        always_ff @(posedge clk) begin
            r_v <= !rst && w_pv[k-1];
            r_d <= w_pd[k-1];
        end
        assign w_pv[k] = r_v;
        assign w_pd[k] = r_d;
    end

    assign w_pop  = data_rvalid_o & data_rready_in;
    assign w_head = r_fifo[r_rp[PW-1:0]];

    // response FIFO storage, written as the last pipeline stage arrives
    always_ff @(posedge clk)
        if (w_pv[READ_LAT-1]) r_fifo[r_wp[PW-1:0]] <= w_pd[READ_LAT-1];

    // FIFO pointers and outstanding-request credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + (PW+1)'(w_pv[READ_LAT-1]);
            r_rp  <= r_rp + (PW+1)'(w_pop);
            r_cnt <= r_cnt + (PW+1)'(w_acc) - (PW+1)'(w_pop);
        end
    end

    assign data_rvalid_o = r_wp != r_rp;
    assign data_rdata_o  = data_rvalid_o ? w_head[31:0] : 32'd0;
    assign data_err_o    = data_rvalid_o & w_head[32];
endmodule

// File: tb/tb_data_ram_pipe.sv
// tb_data_ram_pipe: directed checks of data_ram_pipe with READ_LAT=2, RSP_DEPTH=4.
module tb_data_ram_pipe;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst, req, we, gnt, rvalid, err, rready;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] be;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram_pipe #(.DEPTH(8000), .BASE_ADDR_HI(16'h0010), .READ_LAT(LAT), .RSP_DEPTH(4), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .data_req_in(req), .data_add_in(addr), .data_we_in(we),
        .data_be_in(be), .data_wdata_in(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_rdata_o(rdata), .data_err_o(err), .data_rready_in(rready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        int n = 0;
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        while (!gnt && n < 20) begin
            tick;
            n++;
        end
        chk("gnt_wait", 32'(gnt), 32'd1);
        tick;
        req = 1'b0;
    endtask

    task automatic drain;
        repeat (6) tick;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic e);
        int n = 0;
        drain;
        xfer(1'b0, a, 4'h0, 32'd0);
        while (!rvalid && n < 10) begin
            tick;
            n++;
        end
        chk({tag, "_v"}, 32'(rvalid), 32'd1);
        chk(tag, rdata, exp);
        chk({tag, "_e"}, 32'(err), 32'(e));
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; rready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_gnt", 32'(gnt), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        xfer(1'b1, 32'h0010_0008, 4'hF, 32'h1122_3344);
        chk("wr_rsp_early", 32'(rvalid), 32'd0);
        tick;
        chk("wr_rsp_v", 32'(rvalid), 32'd1);
        chk("wr_rsp_rdata", rdata, 32'd0);
        chk("wr_rsp_err", 32'(err), 32'd0);
        tick;
        req = 1'b1; we = 1'b0; addr = 32'h0010_0008; be = 4'h0;
        chk("lat_gnt", 32'(gnt), 32'd1);
        tick;
        req = 1'b0;
        chk("lat_t1_v", 32'(rvalid), 32'd0);
        tick;
        chk("lat_t2_v", 32'(rvalid), 32'd1);
        chk("lat_rdata", rdata, 32'h1122_3344);
        chk("lat_err", 32'(err), 32'd0);
        tick;
        chk("lat_popped", 32'(rvalid), 32'd0);

        xfer(1'b1, 32'h0010_0008, 4'b0100, 32'h00AA_0000);
        rd("be_lane2", 32'h0010_0008, 32'h11AA_3344, 1'b0);
        xfer(1'b1, 32'h0010_0008, 4'h0, 32'hFFFF_FFFF);
        rd("be_zero", 32'h0010_0008, 32'h11AA_3344, 1'b0);

        xfer(1'b1, 32'h0010_0000, 4'hF, 32'h55AA_55AA);
        for (int i = 0; i < 4; i++) xfer(1'b1, 32'h0010_0010 + 32'(4 * i), 4'hF, 32'hA000_0001 + 32'(i));
        drain;

        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; we = 1'b0; addr = 32'h0010_0010 + 32'(4 * i);
            chk($sformatf("bp_gnt%0d", i), 32'(gnt), 32'd1);
            tick;
        end
        chk("bp_gnt_off", 32'(gnt), 32'd0);
        chk("bp_head_v", 32'(rvalid), 32'd1);
        we = 1'b1; addr = 32'h0010_0010; be = 4'hF; wdata = 32'hFFFF_FFFF;
        tick;
        tick;
        req = 1'b0;
        chk("bp_hold_rdata", rdata, 32'hA000_0001);
        chk("bp_hold_gnt", 32'(gnt), 32'd0);
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_v%0d", i), 32'(rvalid), 32'd1);
            chk($sformatf("bp_rdata%0d", i), rdata, 32'hA000_0001 + 32'(i));
            if (i > 0) chk("bp_gnt_back", 32'(gnt), 32'd1);
            tick;
        end
        chk("bp_empty", 32'(rvalid), 32'd0);
        rd("ignored_wr", 32'h0010_0010, 32'hA000_0001, 1'b0);

        drain;
        xfer(1'b1, 32'h0020_0000, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h0010_7D00, 4'h0, 32'd0);
        chk("oob_wr_v", 32'(rvalid), 32'd1);
        chk("oob_wr_err", 32'(err), 32'd1);
        chk("oob_wr_rdata", rdata, 32'd0);
        tick;
        chk("oob_rd_v", 32'(rvalid), 32'd1);
        chk("oob_rd_err", 32'(err), 32'd1);
        chk("oob_rd_rdata", rdata, 32'd0);
        rd("oob_nochg", 32'h0010_0000, 32'h55AA_55AA, 1'b0);
        xfer(1'b1, 32'h0010_7CFC, 4'hF, 32'h1234_5678);
        rd("last_word", 32'h0010_7CFC, 32'h1234_5678, 1'b0);

        xfer(1'b1, 32'h0010_0008, 4'hF, 32'h1122_3344);
        drain;
`ifdef DATA_RAM_BYTE_SWAP_EN
        chk("backdoor", dut.mem[2], 32'h4433_2211);
`else
        chk("backdoor", dut.mem[2], 32'h1122_3344);
`endif
        rd("swap_rb", 32'h0010_0008, 32'h1122_3344, 1'b0);

        drain;
        rready = 1'b0;
        xfer(1'b0, 32'h0010_0000, 4'h0, 32'd0);
        tick;
        chk("mid_pre_v", 32'(rvalid), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_v", 32'(rvalid), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd1);
        rready = 1'b1;
        rd("mid_rst_keep", 32'h0010_0008, 32'h1122_3344, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
